// File: rtl/add_pipe_pkg.sv
// Shared definitions for the pipelined chunked adder: operation encoding and
// the stage-count derivation used by add_pipe.
package add_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_nstages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/add_chunk.sv
// Combinational CHUNK-bit adder slice; also exposes the carry into its top bit
// so the final stage can form the signed-overflow flag.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign sum   = full[CHUNK-1:0];
  assign co    = full[CHUNK];
  // Carry into the top bit is recovered from that bit's sum equation.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined WIDTH-bit add/subtract: one CHUNK-bit slice per stage, carry
// registered between slices, global-stall valid/ready handshake.
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGES = calc_nstages(WIDTH, CHUNK);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("add_pipe: WIDTH must be a positive multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_in;

  // Every stage moves together; in_ready never looks at in_valid.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign b_eff    = (sub == OP_SUB) ? ~b : b;
  assign c_in     = ci ^ sub;

  for (genvar k = 0; k < NSTAGES; k++) begin : stg
    localparam int LO = CHUNK * k;
    localparam int HI = CHUNK * (k + 1);

    logic [CHUNK-1:0] a_sl, b_sl, sum_sl;
    logic             c_sl, v_sl, co_sl, cmsb_sl;
    logic [HI-1:0]    res_nxt;
    logic             v_r, c_r;
    logic [HI-1:0]    res_r;

    if (k == 0) begin : g_src
      assign a_sl    = a[CHUNK-1:0];
      assign b_sl    = b_eff[CHUNK-1:0];
      assign c_sl    = c_in;
      assign v_sl    = in_valid;
      assign res_nxt = sum_sl;
    end else begin : g_src
      assign a_sl    = stg[k-1].g_ops.a_hi[CHUNK-1:0];
      assign b_sl    = stg[k-1].g_ops.b_hi[CHUNK-1:0];
      assign c_sl    = stg[k-1].c_r;
      assign v_sl    = stg[k-1].v_r;
      assign res_nxt = {sum_sl, stg[k-1].res_r};
    end

    add_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_sl),
      .b     (b_sl),
      .ci    (c_sl),
      .sum   (sum_sl),
      .co    (co_sl),
      .c_msb (cmsb_sl)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        res_r <= '0;
      end else if (adv) begin
        v_r   <= v_sl;
        c_r   <= co_sl;
        res_r <= res_nxt;
      end
    end

    // Operand slices not yet consumed ride along; the last stage needs none.
    if (k < NSTAGES - 1) begin : g_ops
      logic [WIDTH-HI-1:0] a_hi, b_hi;
      logic [WIDTH-HI-1:0] a_hi_nxt, b_hi_nxt;

      if (k == 0) begin : g_from_port
        assign a_hi_nxt = a[WIDTH-1:HI];
        assign b_hi_nxt = b_eff[WIDTH-1:HI];
      end else begin : g_from_prev
        assign a_hi_nxt = stg[k-1].g_ops.a_hi[WIDTH-LO-1:CHUNK];
        assign b_hi_nxt = stg[k-1].g_ops.b_hi[WIDTH-LO-1:CHUNK];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_hi <= '0;
          b_hi <= '0;
        end else if (adv) begin
          a_hi <= a_hi_nxt;
          b_hi <= b_hi_nxt;
        end
      end
    end

    if (k == NSTAGES - 1) begin : g_last
      logic cmsb_r;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cmsb_r <= 1'b0;
        end else if (adv) begin
          cmsb_r <= cmsb_sl;
        end
      end
    end
  end

  assign out_valid = stg[NSTAGES-1].v_r;
  assign sum       = stg[NSTAGES-1].res_r;
  assign co        = stg[NSTAGES-1].c_r;
  assign ovf       = stg[NSTAGES-1].g_last.cmsb_r ^ stg[NSTAGES-1].c_r;
  assign zero      = (sum == '0);

endmodule
